dbus_peri_arbiter: RTL and testbench

//   Shares the single peripheral data bus (dbus2peri side: UART, SPI, test MMIO at 0x8E00_0000 /
//   0x8F00_0000) between NUM_REQ bus masters (core dbus port, debug/loader master, ...).

---
 rtl/dbus_peri_arbiter.sv | 147 ++++++++++++++
 tb/tb_dbus_peri_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_peri_arbiter.sv
// Round-robin arbiter sharing the peripheral data bus between NUM_REQ masters.
// One outstanding transaction, registered request fields, timeout answered with an error response.
module dbus_peri_arbiter #(
    parameter int                NUM_REQ        = 2,
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_sel_i,
    output logic [NUM_REQ-1:0]            req_ack_o,
    output logic                          req_err_o,
    output logic [DATA_W-1:0]             req_rdata_o,
    output logic                          peri_req_o,
    output logic                          peri_we_o,
    output logic [ADDR_W-1:0]             peri_addr_o,
    output logic [DATA_W-1:0]             peri_wdata_o,
    output logic [DATA_W/8-1:0]           peri_sel_o,
    input  logic                          peri_ack_i,
    input  logic [DATA_W-1:0]             peri_rdata_i,
    output logic                          arb_busy_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W-1:0]   pick;
    logic               pick_found;
    logic [PTR_W:0]     cand;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               tmo_hit;
    logic               busy_done;
    logic [NUM_REQ-1:0] grant_onehot;

    // Scan from rr_ptr upward; iterating backwards lets the lowest offset win.
    always_comb begin
        pick       = rr_ptr;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (req_valid_i[cand[PTR_W-1:0]]) begin
                pick       = cand[PTR_W-1:0];
                pick_found = 1'b1;
            end
        end
    end

    assign tmo_hit      = (tmo_cnt == TMO_LAST);
    assign busy_done    = peri_ack_i || tmo_hit;
    assign grant_onehot = {{(NUM_REQ - 1){1'b0}}, 1'b1} << grant;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_found) state_next = BUSY;
            BUSY:    if (busy_done) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            arb_busy_o <= 1'b0;
        end else begin
            state      <= state_next;
            arb_busy_o <= (state_next != IDLE);
        end
    end

    // Datapath; an ack arriving on the timeout cycle takes priority over the error response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            grant        <= '0;
            tmo_cnt      <= '0;
            req_ack_o    <= '0;
            req_err_o    <= 1'b0;
            req_rdata_o  <= '0;
            peri_req_o   <= 1'b0;
            peri_we_o    <= 1'b0;
            peri_addr_o  <= '0;
            peri_wdata_o <= '0;
            peri_sel_o   <= '0;
        end else begin
            req_ack_o <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant        <= pick;
                        peri_we_o    <= req_we_i[pick];
                        peri_addr_o  <= req_addr_i[int'(pick) * ADDR_W +: ADDR_W];
                        peri_wdata_o <= req_wdata_i[int'(pick) * DATA_W +: DATA_W];
                        peri_sel_o   <= req_sel_i[int'(pick) * SEL_W +: SEL_W];
                        tmo_cnt      <= '0;
                        peri_req_o   <= 1'b1;
                    end
                end
                BUSY: begin
                    if (peri_ack_i) begin
                        req_rdata_o <= peri_rdata_i;
                        req_err_o   <= 1'b0;
                    end else if (tmo_hit) begin
                        req_rdata_o <= ERR_RDATA;
                        req_err_o   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (busy_done) begin
                        peri_req_o <= 1'b0;
                        req_ack_o  <= grant_onehot;
                    end
                end
                RESP: begin
                    rr_ptr <= (grant == LAST_REQ) ? '0 : grant + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_peri_arbiter.sv
// Randomized scoreboard bench for dbus_peri_arbiter: a transaction-level round-robin model
// predicts grant order and responses; a peripheral responder and a response monitor check them.
module tb_dbus_peri_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = DATA_W / 8;
    localparam int TMO     = 8;
    localparam logic [DATA_W-1:0] ERR_VAL = 32'hDEADBEEF;

    logic                        clk = 1'b0;
    logic                        reset = 1'b1;
    logic [NUM_REQ-1:0]          req_valid_i;
    logic [NUM_REQ-1:0]          req_we_i;
    logic [NUM_REQ*ADDR_W-1:0]   req_addr_i;
    logic [NUM_REQ*DATA_W-1:0]   req_wdata_i;
    logic [NUM_REQ*SEL_W-1:0]    req_sel_i;
    logic [NUM_REQ-1:0]          req_ack_o;
    logic                        req_err_o;
    logic [DATA_W-1:0]           req_rdata_o;
    logic                        peri_req_o;
    logic                        peri_we_o;
    logic [ADDR_W-1:0]           peri_addr_o;
    logic [DATA_W-1:0]           peri_wdata_o;
    logic [SEL_W-1:0]            peri_sel_o;
    logic                        peri_ack_i;
    logic [DATA_W-1:0]           peri_rdata_i;
    logic                        arb_busy_o;

    dbus_peri_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR_VAL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_sel_i(req_sel_i),
        .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_rdata_o(req_rdata_o),
        .peri_req_o(peri_req_o), .peri_we_o(peri_we_o), .peri_addr_o(peri_addr_o),
        .peri_wdata_o(peri_wdata_o), .peri_sel_o(peri_sel_o),
        .peri_ack_i(peri_ack_i), .peri_rdata_i(peri_rdata_i), .arb_busy_o(arb_busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                delay;
        logic [DATA_W-1:0] rdata;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [SEL_W-1:0]  sel;
    } plan_t;

    typedef struct {
        logic [NUM_REQ-1:0] onehot;
        logic               err;
        logic               chk_rdata;
        logic [DATA_W-1:0]  rdata;
    } exp_t;

    plan_t plan_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    rr_model = 0;
    bit    allow_unplanned = 1'b0;

    logic              stim_we[NUM_REQ];
    logic [ADDR_W-1:0] stim_addr[NUM_REQ];
    logic [DATA_W-1:0] stim_wdata[NUM_REQ];
    logic [SEL_W-1:0]  stim_sel[NUM_REQ];
    logic [DATA_W-1:0] stim_rdata[NUM_REQ];
    int                stim_delay[NUM_REQ];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic randomizeStim();
        for (int k = 0; k < NUM_REQ; k++) begin
            stim_we[k]    = 1'($urandom_range(0, 1));
            stim_addr[k]  = ($urandom_range(0, 1) == 0 ? 32'h8E00_0000 : 32'h8F00_0000)
                            | ($urandom & 32'h0000_FFFC);
            stim_wdata[k] = $urandom;
            stim_sel[k]   = 4'($urandom_range(1, 15));
            stim_rdata[k] = $urandom;
            stim_delay[k] = int'($urandom_range(0, 9));
        end
    endtask

    // Model: each pick is the first pending master scanning from rr_model; rr_model then moves past it.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input bit drop_early);
        logic [NUM_REQ-1:0] rem;
        logic [NUM_REQ-1:0] pend;
        int    k;
        int    budget;
        int    n_acks;
        int    prev_cyc;
        int    ord_len[$];
        plan_t p;
        exp_t  e;
        rem = mask;
        while (rem != '0) begin
            k = 0;
            for (int n = 0; n < NUM_REQ; n++) begin
                k = (rr_model + n) % NUM_REQ;
                if (rem[k]) break;
            end
            p.delay = stim_delay[k];
            p.rdata = stim_rdata[k];
            p.we    = stim_we[k];
            p.addr  = stim_addr[k];
            p.wdata = stim_wdata[k];
            p.sel   = stim_sel[k];
            plan_q.push_back(p);
            e.onehot    = NUM_REQ'(1) << k;
            e.err       = (stim_delay[k] >= TMO);
            e.chk_rdata = e.err || !stim_we[k];
            e.rdata     = e.err ? ERR_VAL : stim_rdata[k];
            exp_q.push_back(e);
            ord_len.push_back(stim_delay[k] < TMO ? stim_delay[k] + 1 : TMO);
            rem[k]   = 1'b0;
            rr_model = (k + 1) % NUM_REQ;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (mask[j]) begin
                req_we_i[j]                       = stim_we[j];
                req_addr_i[j*ADDR_W +: ADDR_W]    = stim_addr[j];
                req_wdata_i[j*DATA_W +: DATA_W]   = stim_wdata[j];
                req_sel_i[j*SEL_W +: SEL_W]       = stim_sel[j];
            end
        end
        req_valid_i = mask;
        pend = mask;
        @(negedge clk);
        checkOutput("valid_to_peri_req", 128'(peri_req_o), 128'd1);
        if (drop_early) req_valid_i = '0;
        budget   = 40 * NUM_REQ;
        n_acks   = 0;
        prev_cyc = 0;
        while (pend != '0 && budget > 0) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (pend[j] && req_ack_o[j]) begin
                    req_valid_i[j] = 1'b0;
                    pend[j] = 1'b0;
                    req_addr_i[j*ADDR_W +: ADDR_W]  = $urandom;
                    req_wdata_i[j*DATA_W +: DATA_W] = $urandom;
                    req_we_i[j] = 1'($urandom_range(0, 1));
                    if (n_acks > 0)
                        checkOutput("ack_spacing", 128'(cyc - prev_cyc), 128'(ord_len[n_acks] + 2));
                    prev_cyc = cyc;
                    n_acks++;
                end
            end
            if (pend != '0) begin
                @(negedge clk);
                budget--;
            end
        end
        if (pend != '0) begin
            checkOutput("batch_complete", 128'(pend), 128'd0);
            req_valid_i = '0;
        end
        @(negedge clk);
        checkOutput("busy_after_batch", 128'(arb_busy_o), 128'd0);
    endtask

    // Peripheral responder: acks after the planned delay and checks what the arbiter presents.
    initial begin : responder
        plan_t cur;
        int    cnt;
        bit    active;
        bit    noplan;
        int    late_left;
        active = 1'b0; noplan = 1'b0; cnt = 0; late_left = 0;
        cur.delay = 0;
        peri_ack_i = 1'b0;
        peri_rdata_i = '0;
        forever begin
            @(negedge clk);
            peri_ack_i = (late_left > 0);
            if (late_left > 0) late_left--;
            if (reset) begin
                active = 1'b0; cnt = 0; late_left = 0; peri_ack_i = 1'b0;
            end else if (peri_req_o) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = 0;
                    if (plan_q.size() > 0) begin
                        cur = plan_q.pop_front();
                        noplan = 1'b0;
                    end else begin
                        noplan = 1'b1;
                        cur.delay = 1 << 20;
                        if (!allow_unplanned) checkOutput("unplanned_peri_req", 128'd1, 128'd0);
                    end
                end
                if (!noplan)
                    checkOutput("peri_fields", 128'({peri_we_o, peri_addr_o, peri_wdata_o, peri_sel_o}),
                                128'({cur.we, cur.addr, cur.wdata, cur.sel}));
                if (cnt == cur.delay) begin
                    peri_ack_i = 1'b1;
                    peri_rdata_i = cur.rdata;
                end else begin
                    peri_rdata_i = $urandom;
                end
                cnt++;
            end else if (active) begin
                if (!noplan) begin
                    checkOutput("peri_req_cycles", 128'(cnt),
                                128'(cur.delay < TMO ? cur.delay + 1 : TMO));
                    checkOutput("resp_after_peri", 128'(req_ack_o != '0), 128'd1);
                    if (cur.delay >= TMO) begin
                        peri_ack_i = 1'b1;
                        peri_rdata_i = $urandom;
                        late_left = 1;
                    end
                end
                active = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && req_ack_o != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_req_ack", 128'(req_ack_o), 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("req_ack_onehot", 128'(req_ack_o), 128'(e.onehot));
                    checkOutput("req_err", 128'(req_err_o), 128'(e.err));
                    if (e.chk_rdata) checkOutput("req_rdata", 128'(req_rdata_o), 128'(e.rdata));
                    checkOutput("busy_in_resp", 128'(arb_busy_o), 128'd1);
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual running required done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int            w;
        logic [NUM_REQ-1:0] mask;
        req_valid_i = '0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0; req_sel_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ack", 128'(req_ack_o), 128'd0);
        checkOutput("rst_req_err", 128'(req_err_o), 128'd0);
        checkOutput("rst_req_rdata", 128'(req_rdata_o), 128'd0);
        checkOutput("rst_peri_req", 128'(peri_req_o), 128'd0);
        checkOutput("rst_peri_fields", 128'({peri_we_o, peri_addr_o, peri_wdata_o, peri_sel_o}), 128'd0);
        checkOutput("rst_busy", 128'(arb_busy_o), 128'd0);
        reset = 1'b0;
        @(negedge clk);

        randomizeStim();
        stim_we[0] = 1'b1; stim_addr[0] = 32'h8E00_0000; stim_wdata[0] = 32'h1234_5678;
        stim_sel[0] = 4'hF; stim_delay[0] = 0;
        applyStimulus(2'b01, 1'b0);

        randomizeStim();
        stim_we[1] = 1'b0; stim_addr[1] = 32'h8F00_0000; stim_rdata[1] = 32'hCAFE_F00D;
        stim_delay[1] = 5;
        applyStimulus(2'b10, 1'b0);

        for (int r = 0; r < 3; r++) begin
            randomizeStim();
            stim_delay[0] = 0; stim_delay[1] = 0;
            applyStimulus(2'b11, 1'b0);
        end

        randomizeStim();
        stim_delay[0] = TMO;
        applyStimulus(2'b01, 1'b0);
        @(negedge clk);
        checkOutput("late_ack_ignored", 128'(arb_busy_o), 128'd0);

        randomizeStim();
        stim_we[1] = 1'b0; stim_delay[1] = TMO - 1;
        applyStimulus(2'b10, 1'b0);

        randomizeStim();
        stim_delay[0] = 2;
        applyStimulus(2'b01, 1'b1);

        for (int r = 0; r < 40; r++) begin
            mask = NUM_REQ'($urandom_range(1, 3));
            randomizeStim();
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(mask, (mask != 2'b11) && ($urandom_range(0, 3) == 0));
        end

        randomizeStim();
        stim_delay[0] = 1;
        applyStimulus(2'b01, 1'b0);
        allow_unplanned = 1'b1;
        req_we_i[1] = 1'b1;
        req_addr_i[ADDR_W +: ADDR_W] = 32'h8E00_0010;
        req_valid_i = 2'b10;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!peri_req_o && w < 10);
        checkOutput("reset_test_reached_busy", 128'(peri_req_o), 128'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("reset_drops_peri_req", 128'(peri_req_o), 128'd0);
        checkOutput("reset_drops_busy", 128'(arb_busy_o), 128'd0);
        checkOutput("reset_drops_ack", 128'(req_ack_o), 128'd0);
        req_valid_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rr_model = 0;
        allow_unplanned = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset", 128'(arb_busy_o), 128'd0);
        randomizeStim();
        applyStimulus(2'b11, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        checkOutput("plans_consumed", 128'(plan_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
